game_state_fsm: RTL
===================

# game_state_fsm

Frame-rate game sequencer that sits directly downstream of the collision controller. It consumes the single-per-frame hit pulse and the tile type of the hit, and owns game phase, level number, lives, BCD score and the per-level countdown. It drives the ball-motion enable and the level-load request consumed by the ball/tile-map blocks. It also feeds the score/time/lives values to the seven-segment/HUD logic.

## Interface
Parameters:
- LIVES_INIT, 3: lives at game start (1..3)
- NUM_LEVELS, 4: levels per game (1..4)
- LEVEL_TIME_S, 60: countdown seconds per level (1..99)
- FRAMES_PER_SEC, 30: startOfFrame pulses per second
- GIFT_POINTS, 5: BCD points per gift (1..9)
- FREEZE_FRAMES, 30: frames of motion freeze after life loss or level change

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per frame
- start_key  in  1  level-sensitive start button, already debounced
- SingleHitPulse  in  1  one-cycle pulse, at most one per frame
- TileType  in  2  tile of the hit, valid in the SingleHitPulse cycle; 00 background, 01 floor, 10 gift, 11 hole
- state  out  3  current phase encoding
- level  out  2  zero-based level index
- lives  out  2  remaining lives
- score  out  12  three BCD digits
- time_left  out  7  binary seconds remaining
- motion_en  out  1  ball may move
- level_load  out  1  one-cycle pulse requesting tile-map/ball reload
- game_over  out  1  high in S_OVER
- game_won  out  1  high in S_WON

## Operation
- States: S_IDLE(0), S_LOAD(1), S_FREEZE(2), S_PLAY(3), S_OVER(4), S_WON(5).
- S_IDLE: on start_key rising edge, do the following, then go to S_LOAD:
  - lives=LIVES_INIT, level=0, score=0.
- S_LOAD: one cycle.
  - level_load=1, time_left=LEVEL_TIME_S, frame counter cleared.
  - Then go to S_FREEZE with freeze counter=FREEZE_FRAMES.
- S_FREEZE: motion_en=0. Decrement the freeze counter on each startOfFrame. At 0, go to S_PLAY.
- S_PLAY: motion_en=1.
  - Frame counter counts startOfFrame pulses 0..FRAMES_PER_SEC-1. On wrap, decrement time_left.
  - Hit with TileType=10 (gift): add GIFT_POINTS in BCD. Score saturates at 999.
  - Hit with TileType=11 (hole/exit): if level==NUM_LEVELS-1, go to S_WON. Otherwise level+1, then S_LOAD.
  - Hit with TileType 00/01: no effect.
  - time_left reaching 0: lives-1. If the result is 0, go to S_OVER. Otherwise go to S_LOAD at the same level.
- S_OVER / S_WON: outputs frozen, motion_en=0. start_key rising edge returns to S_IDLE.
- Simultaneous hole hit and timeout in the same cycle: the hole wins; no life is lost.
- Simultaneous gift hit and timeout: points are added and the life is lost.
- SingleHitPulse outside S_PLAY is ignored.
- start_key edge detector uses one registered copy. start_key held high through reset does not count as an edge.

## Timing
- Reset values:
  - state=S_IDLE, level=0, lives=LIVES_INIT, score=0, time_left=LEVEL_TIME_S.
  - motion_en=0, level_load=0, game_over=0, game_won=0.
- All outputs are registered. A hit updates score/state on the clock edge ending the pulse cycle, visible next cycle.
- Latency: start edge → level_load at +2 cycles (edge register, then S_LOAD). Hole hit → level_load at +2.
- Time decrement happens on the same edge as the wrapping startOfFrame. time_left never underflows below 0.
- Freeze lasts exactly FREEZE_FRAMES startOfFrame pulses. A startOfFrame in the S_LOAD cycle is not counted.
- Reset mid-operation returns to the reset values immediately (asynchronously). No level_load is issued until the next start.

## Structure
- Shared package (game_pkg): state enum, TileType localparams (TILETYPE_BACKGROUND/FLOOR/GIFT/HOLE), BCD digit type.
- Sub-module bcd_add3: 3-digit BCD adder with a 1-digit addend and saturation at 999. Combinational, instantiated once.
- Frame, second and freeze counters live in the FSM module.

## Test plan
- Reset, then start_key pulse → level_load at +2 cycles. After 30 startOfFrame pulses motion_en=1, lives=3, time_left=60.
- In S_PLAY, 3 hits with TileType=10 → score=0x015. Hits with TileType=01 → score unchanged.
- Score at 0x997 plus a gift → 0x999 (saturated).
- Hole hit on levels 0..2 → level increments with level_load each time. Hole on level 3 → game_won=1, motion_en=0.
- LEVEL_TIME_S=2: 60 frames in S_PLAY → lives 3→2 and reload. Repeat until lives=0 → game_over=1.
- Hole hit and the timeout-wrap frame in the same cycle → level+1, lives unchanged.
- Assert reset mid-S_PLAY → all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types for the game sequencer: phase encoding, tile codes, BCD digit.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FREEZE = 3'd2,
        S_PLAY   = 3'd3,
        S_OVER   = 3'd4,
        S_WON    = 3'd5
    } state_t;

    localparam logic [1:0] TILETYPE_BACKGROUND = 2'b00;
    localparam logic [1:0] TILETYPE_FLOOR      = 2'b01;
    localparam logic [1:0] TILETYPE_GIFT       = 2'b10;
    localparam logic [1:0] TILETYPE_HOLE       = 2'b11;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_add3.sv
// Three-digit BCD adder with a single-digit addend; result clamps at 999.
module bcd_add3
    import game_pkg::*;
(
    input  logic [11:0] a,
    input  bcd_digit_t  b,
    output logic [11:0] sum
);

    logic [4:0] t0, t1, t2;
    logic       c0, c1, c2;
    bcd_digit_t s0, s1;

    always_comb begin
        t0 = {1'b0, a[3:0]} + {1'b0, b};
        c0 = (t0 > 5'd9);
        s0 = c0 ? 4'(t0 - 5'd10) : t0[3:0];
        t1 = {1'b0, a[7:4]} + {4'b0, c0};
        c1 = (t1 > 5'd9);
        s1 = c1 ? 4'(t1 - 5'd10) : t1[3:0];
        t2 = {1'b0, a[11:8]} + {4'b0, c1};
        c2 = (t2 > 5'd9);
        // a carry out of the hundreds digit means the true sum passed 999
        sum = c2 ? 12'h999 : {t2[3:0], s1, s0};
    end

endmodule

// File: rtl/game_state_fsm.sv
// Game phase sequencer: owns level, lives, BCD score, per-level countdown and motion gating.
module game_state_fsm
    import game_pkg::*;
#(
    parameter int LIVES_INIT     = 3,
    parameter int NUM_LEVELS     = 4,
    parameter int LEVEL_TIME_S   = 60,
    parameter int FRAMES_PER_SEC = 30,
    parameter int GIFT_POINTS    = 5,
    parameter int FREEZE_FRAMES  = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        start_key,
    input  logic        SingleHitPulse,
    input  logic [1:0]  TileType,
    output logic [2:0]  state,
    output logic [1:0]  level,
    output logic [1:0]  lives,
    output logic [11:0] score,
    output logic [6:0]  time_left,
    output logic        motion_en,
    output logic        level_load,
    output logic        game_over,
    output logic        game_won
);

    localparam int FRAME_W  = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int FREEZE_W = $clog2(FREEZE_FRAMES + 1);

    state_t              state_q, state_d;
    logic [1:0]          level_q, level_d, lives_q, lives_d;
    logic [11:0]         score_q, score_d, score_sum;
    logic [6:0]          time_q, time_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [FREEZE_W-1:0] freeze_q, freeze_d;
    logic                start_q, start_edge, timeout;
    logic                motion_en_q, motion_en_d, level_load_q, level_load_d;
    logic                game_over_q, game_over_d, game_won_q, game_won_d;

    // start_q resets high so a key held through reset is not taken as a press
    assign start_edge = start_key & ~start_q;

    bcd_add3 u_bcd_add3 (
        .a   (score_q),
        .b   (4'(GIFT_POINTS)),
        .sum (score_sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            level_q      <= '0;
            lives_q      <= 2'(LIVES_INIT);
            score_q      <= '0;
            time_q       <= 7'(LEVEL_TIME_S);
            frame_q      <= '0;
            freeze_q     <= '0;
            start_q      <= 1'b1;
            motion_en_q  <= 1'b0;
            level_load_q <= 1'b0;
            game_over_q  <= 1'b0;
            game_won_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            time_q       <= time_d;
            frame_q      <= frame_d;
            freeze_q     <= freeze_d;
            start_q      <= start_key;
            motion_en_q  <= motion_en_d;
            level_load_q <= level_load_d;
            game_over_q  <= game_over_d;
            game_won_q   <= game_won_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        lives_d  = lives_q;
        score_d  = score_q;
        time_d   = time_q;
        frame_d  = frame_q;
        freeze_d = freeze_q;
        timeout  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    lives_d = 2'(LIVES_INIT);
                    level_d = '0;
                    score_d = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                time_d   = 7'(LEVEL_TIME_S);
                frame_d  = '0;
                freeze_d = FREEZE_W'(FREEZE_FRAMES);
                state_d  = S_FREEZE;
            end
            S_FREEZE: begin
                if (startOfFrame) begin
                    freeze_d = freeze_q - FREEZE_W'(1);
                    if (freeze_q <= FREEZE_W'(1)) state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (startOfFrame) begin
                    if (frame_q == FRAME_W'(FRAMES_PER_SEC - 1)) begin
                        frame_d = '0;
                        if (time_q != 7'd0) begin
                            time_d  = time_q - 7'd1;
                            timeout = (time_q == 7'd1);
                        end
                    end else begin
                        frame_d = frame_q + FRAME_W'(1);
                    end
                end
                if (SingleHitPulse && TileType == TILETYPE_GIFT) score_d = score_sum;
                // an exit hit takes priority over a timeout landing on the same edge
                if (SingleHitPulse && TileType == TILETYPE_HOLE) begin
                    if (level_q == 2'(NUM_LEVELS - 1)) begin
                        state_d = S_WON;
                    end else begin
                        level_d = level_q + 2'd1;
                        state_d = S_LOAD;
                    end
                end else if (timeout) begin
                    lives_d = lives_q - 2'd1;
                    state_d = (lives_q == 2'd1) ? S_OVER : S_LOAD;
                end
            end
            S_OVER, S_WON: begin
                if (start_edge) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        motion_en_d  = (state_d == S_PLAY);
        level_load_d = (state_q == S_LOAD);
        game_over_d  = (state_d == S_OVER);
        game_won_d   = (state_d == S_WON);
    end

    assign state      = state_q;
    assign level      = level_q;
    assign lives      = lives_q;
    assign score      = score_q;
    assign time_left  = time_q;
    assign motion_en  = motion_en_q;
    assign level_load = level_load_q;
    assign game_over  = game_over_q;
    assign game_won   = game_won_q;

endmodule
